// File: rtl/counter_ctrl.sv
// counter_ctrl: two-requester round-robin scheduler for one shared W-bit
// loadable up-counter used as an interval timer. The winner's start value is
// loaded into the counter. The counter is then enabled until it matches the
// winner's terminal value. A one-cycle done pulse goes to that requester and
// the counter is released.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   req[1:0]          per-requester request
//   start0/1, term0/1 per-requester start and terminal values, sampled at grant
//   gnt[1:0]          one-hot grant, held from LOAD through DONE
//   done[1:0]         one-cycle completion pulse to the granted requester
//   busy              high whenever the scheduler is not idle
//   ctr_load, ctr_en  drive the shared counter's load / en pins
//   ctr_data          drives the shared counter's data_in (holds start_q)
//   ctr_cnt           the shared counter's registered count
module counter_ctrl #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req,
  input  logic [W-1:0] start0,
  input  logic [W-1:0] start1,
  input  logic [W-1:0] term0,
  input  logic [W-1:0] term1,
  output logic [1:0]   gnt,
  output logic [1:0]   done,
  output logic         busy,
  output logic         ctr_load,
  output logic         ctr_en,
  output logic [W-1:0] ctr_data,
  input  logic [W-1:0] ctr_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  state_t       state, state_nxt;
  logic         g, g_nxt;          // index of the granted requester
  logic         last, last_nxt;    // most recently served requester
  logic [W-1:0] start_q, start_nxt;
  logic [W-1:0] term_q, term_nxt;
  logic         win;
  logic [1:0]   g_oh;

  // Under contention the requester that was not served last wins.
  always_comb begin
    win = req[1];
    if (req == 2'b11) win = ~last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      g       <= 1'b0;
      last    <= 1'b1;
      start_q <= '0;
      term_q  <= '0;
    end else begin
      state   <= state_nxt;
      g       <= g_nxt;
      last    <= last_nxt;
      start_q <= start_nxt;
      term_q  <= term_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    g_nxt     = g;
    last_nxt  = last;
    start_nxt = start_q;
    term_nxt  = term_q;
    case (state)
      S_IDLE: begin
        if (|req) begin
          g_nxt     = win;
          start_nxt = win ? start1 : start0;
          term_nxt  = win ? term1 : term0;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (!req[g]) begin
          last_nxt  = g;
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        // A dropped request aborts even on the cycle the terminal value is hit.
        if (!req[g]) begin
          last_nxt  = g;
          state_nxt = S_IDLE;
        end else if (ctr_cnt == term_q) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        last_nxt  = g;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    g_oh     = g ? 2'b10 : 2'b01;
    busy     = (state != S_IDLE);
    gnt      = busy ? g_oh : '0;
    done     = (state == S_DONE) ? g_oh : '0;
    ctr_load = (state == S_LOAD);
    ctr_en   = (state == S_RUN) && (ctr_cnt != term_q);
    ctr_data = start_q;
  end

endmodule

// File: tb/tb_counter_ctrl.sv
module tb_counter_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req = '0;
  logic [7:0] start0 = '0, start1 = '0, term0 = '0, term1 = '0;
  logic [1:0] gnt, done;
  logic       busy, ctr_load, ctr_en;
  logic [7:0] ctr_data;
  logic [7:0] cnt = '0;

  int total = 0;
  int bad = 0;

  counter_ctrl #(.W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .start0   (start0),
    .start1   (start1),
    .term0    (term0),
    .term1    (term1),
    .gnt      (gnt),
    .done     (done),
    .busy     (busy),
    .ctr_load (ctr_load),
    .ctr_en   (ctr_en),
    .ctr_data (ctr_data),
    .ctr_cnt  (cnt)
  );

  always #5 clk = ~clk;

  // Shared 8-bit counter: load beats en, +1 with natural wrap, no reset.
  always @(posedge clk) begin
    if (ctr_load)    cnt <= ctr_data;
    else if (ctr_en) cnt <= cnt + 8'd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One single-requester transaction, sampled on falling edges. Start/term
  // inputs are scrambled after the grant to show they are ignored.
  task automatic run_txn(input logic [1:0] r, output int n_gnt, output int n_en,
                         output int n_load, output int done_idx, output logic [1:0] done_v,
                         output logic [7:0] ldata, output logic [7:0] cnt_done);
    bit seen = 0;
    bit fin = 0;
    n_gnt = 0; n_en = 0; n_load = 0; done_idx = 0; done_v = '0; ldata = '0; cnt_done = '0;
    req = r;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (gnt != 2'b00) n_gnt++;
      if (n_gnt == 1) begin
        start0 = 8'h55; start1 = 8'h55; term0 = 8'hC3; term1 = 8'hC3;
      end
      if (ctr_en) n_en++;
      if (ctr_load) begin
        n_load++;
        ldata = ctr_data;
      end
      if (done != 2'b00) begin
        done_v = done;
        done_idx = n_gnt;
        cnt_done = cnt;
        req = '0;
        seen = 1;
      end else if (seen && gnt == 2'b00) begin
        fin = 1;
        break;
      end
    end
    check("txn_timeout", {31'd0, fin}, 32'd1);
  endtask

  int n_gnt, n_en, n_load, done_idx;
  logic [1:0] done_v;
  logic [7:0] ldata, cnt_done;

  initial begin
    // Reset held from time 0.
    repeat (3) @(negedge clk);
    check("rst_gnt", {30'd0, gnt}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_data", {24'd0, ctr_data}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic: N = 4
    start0 = 8'd10; term0 = 8'd14;
    run_txn(2'b01, n_gnt, n_en, n_load, done_idx, done_v, ldata, cnt_done);
    check("basic_gnt_cycles", n_gnt, 7);
    check("basic_load_cycles", n_load, 1);
    check("basic_load_data", {24'd0, ldata}, 10);
    check("basic_en_cycles", n_en, 4);
    check("basic_cnt", {24'd0, cnt_done}, 14);
    check("basic_done", {30'd0, done_v}, 32'h1);
    check("basic_done_idx", done_idx, 7);
    check("basic_busy_after", {31'd0, busy}, 0);

    // Wrap: 250 -> 3, N = 9
    start1 = 8'd250; term1 = 8'd3;
    run_txn(2'b10, n_gnt, n_en, n_load, done_idx, done_v, ldata, cnt_done);
    check("wrap_en_cycles", n_en, 9);
    check("wrap_gnt_cycles", n_gnt, 12);
    check("wrap_load_data", {24'd0, ldata}, 250);
    check("wrap_cnt", {24'd0, cnt_done}, 3);
    check("wrap_done", {30'd0, done_v}, 32'h2);

    // Zero length
    start0 = 8'd77; term0 = 8'd77;
    run_txn(2'b01, n_gnt, n_en, n_load, done_idx, done_v, ldata, cnt_done);
    check("zero_en_cycles", n_en, 0);
    check("zero_done_idx", done_idx, 3);
    check("zero_done", {30'd0, done_v}, 32'h1);

    // Asynchronous reset mid-operation
    start0 = 8'd0; term0 = 8'd50;
    req = 2'b01;
    repeat (5) @(negedge clk);
    check("pre_rst_busy", {31'd0, busy}, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_gnt", {30'd0, gnt}, 0);
    check("arst_busy", {31'd0, busy}, 0);
    check("arst_en", {31'd0, ctr_en}, 0);
    check("arst_load", {31'd0, ctr_load}, 0);
    check("arst_data", {24'd0, ctr_data}, 0);
    req = '0;
    @(negedge clk);
    @(negedge clk);
    check("arst_hold_busy", {31'd0, busy}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Contention after reset: lengths 2 and 3, grants alternate from 0.
    begin
      logic [1:0] seq[$];
      logic [1:0] prev = '0;
      int gap = 0;
      int gap_bad = 0;
      int d0 = 0, d1 = 0, done_wrong = 0;
      start0 = 8'd0; term0 = 8'd2; start1 = 8'd0; term1 = 8'd3;
      req = 2'b11;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (gnt != 2'b00 && prev == 2'b00) begin
          if (seq.size() > 0 && gap != 1) gap_bad++;
          seq.push_back(gnt);
          gap = 0;
        end
        if (gnt == 2'b00) gap++;
        if (done != 2'b00) begin
          if (done != gnt) done_wrong++;
          if (done == 2'b01) d0++;
          if (done == 2'b10) d1++;
          if (d0 + d1 == 4) req = '0;
        end
        prev = gnt;
        if (d0 + d1 == 4 && gnt == 2'b00) break;
      end
      check("cont_num_grants", seq.size(), 4);
      if (seq.size() == 4) begin
        check("cont_g0", {30'd0, seq[0]}, 32'h1);
        check("cont_g1", {30'd0, seq[1]}, 32'h2);
        check("cont_g2", {30'd0, seq[2]}, 32'h1);
        check("cont_g3", {30'd0, seq[3]}, 32'h2);
      end
      check("cont_done0", d0, 2);
      check("cont_done1", d1, 2);
      check("cont_done_match", done_wrong, 0);
      check("cont_idle_gap", gap_bad, 0);
    end
    @(negedge clk);

    // Abort: requester 1 drops at cnt 5 of target 20, req0 pending.
    begin
      bit hit = 0;
      start1 = 8'd2; term1 = 8'd20; start0 = 8'd30; term0 = 8'd31;
      req = 2'b10;
      @(negedge clk);
      check("abort_gnt1", {30'd0, gnt}, 32'h2);
      req = 2'b11;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (gnt == 2'b10 && ctr_en && cnt == 8'd5) begin
          hit = 1;
          break;
        end
      end
      check("abort_reach5", {31'd0, hit}, 1);
      req = 2'b01;
      @(negedge clk);
      check("abort_gnt", {30'd0, gnt}, 0);
      check("abort_en", {31'd0, ctr_en}, 0);
      check("abort_no_done", {30'd0, done}, 0);
      @(negedge clk);
      check("abort_next_gnt", {30'd0, gnt}, 32'h1);
      check("abort_next_load", {31'd0, ctr_load}, 1);
      check("abort_next_data", {24'd0, ctr_data}, 30);
      req = '0;
      @(negedge clk);
      check("abort_final_busy", {31'd0, busy}, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter_ctrl.md
# counter_ctrl

Two-requester scheduler that shares one 8-bit loadable up-counter as an interval timer. Each requester supplies a start value and a terminal value. The block arbitrates round-robin, loads the counter with the winner's start value, and enables counting until the counter reaches the terminal value. It then pulses `done` to that requester and releases the counter. It sits between client logic and the team's 8-bit counter, where `load` has priority over `en`, the increment is +1 and the count wraps 255→0, and drives that counter's `load`, `en` and `data_in` pins.

## Interface
- `W`, 8, counter/value width; must match the shared counter.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req` input 2: request per requester; bit i is requester i.
- `start0`, `start1` input W: start value for requester 0 / 1, sampled at grant.
- `term0`, `term1` input W: terminal value for requester 0 / 1, sampled at grant.
- `gnt` output 2: one-hot grant, held from LOAD through DONE.
- `done` output 2: one-cycle completion pulse to the granted requester.
- `busy` output 1: high whenever state ≠ IDLE.
- `ctr_load` output 1: drives counter `load`.
- `ctr_en` output 1: drives counter `en`.
- `ctr_data` output W: drives counter `data_in`.
- `ctr_cnt` input W: counter `cnt` value (registered in the counter).

## Operation
- **States:** IDLE, LOAD, RUN, DONE. All are registered; outputs are decoded from state and latched values.

**IDLE**
- If any `req` bit is high, select a winner:
  - With a single request, the requester that is asserting wins.
  - With both requesting, the requester other than `last` wins.
- `last` resets to 1, so requester 0 wins the first contention.
- At the grant, latch `start_q` and `term_q` from the winner's inputs, set `gnt`, and go to LOAD.

**LOAD (one cycle)**
- `ctr_load`=1 and `ctr_data`=`start_q`.
- Go to RUN.

**RUN**
- `ctr_en` = (`ctr_cnt` ≠ `term_q`), combinational.
- When `ctr_cnt` == `term_q`, go to DONE.
- The counter therefore increments N = (`term_q` − `start_q`) mod 2^W times; wrap-around through 0 is legal.

**DONE (one cycle)**
- `done[g]`=1, `gnt` is still high.
- Set `last` = g and go to IDLE.

**Abort**
- If `req[g]` falls during LOAD or RUN, go to IDLE on the next edge with `ctr_en`=0 and no `done` pulse.
- `last` is updated to g.

**Other rules**
- `ctr_data` holds `start_q` in every state; it is only meaningful while `ctr_load` is high.
- Start and term input changes after the grant are ignored.
- A request still high in IDLE after DONE is re-arbitrated normally. With both requests held, grants alternate.
- Reset mid-operation: all outputs drop immediately, the FSM goes to IDLE and the counter's own state is not touched.

**Reset values**
- state=IDLE, `gnt`=0, `done`=0, `busy`=0, `ctr_load`=0, `ctr_en`=0, `ctr_data`=0, `last`=1, `start_q`=`term_q`=0.

## Timing
- With `req` sampled high in IDLE at edge e, LOAD occupies the cycle after edge e, and `gnt` and `busy` rise at edge e.
- The counter holds `start_q` from edge e+1, which is the first RUN cycle.
- RUN lasts N+1 cycles; `ctr_en` is high for the first N of them.
- DONE follows for one cycle, so `gnt` is high for N+3 cycles.
- `done` is high in the cycle after edge e+N+2.
- There is at least one IDLE cycle between consecutive grants.
- `done` and `gnt` fall together at the edge leaving DONE.

## Test plan
- **Reset:** assert `rst_n`=0 asynchronously mid-cycle → all outputs are 0 immediately and remain 0 until `rst_n`=1; the first grant with both `req` bits high goes to requester 0.
- **Basic:** `req`=01, `start0`=10, `term0`=14 →
  - `gnt`=01 for 7 cycles, `ctr_load` high for 1 cycle with `ctr_data`=10;
  - `ctr_en` high for 4 cycles, `ctr_cnt` reaches 14;
  - `done`=01 for one cycle, then `busy`=0.
- **Wrap:** `req`=10, `start1`=250, `term1`=3 → `ctr_en` high for 9 cycles, `ctr_cnt` goes 250…255, 0…3, then `done`=10.
- **Zero length:** `start0`=`term0`=77 → `ctr_en` never high; `done`=01 appears 3 cycles after the grant.
- **Contention:** `req`=11 held with lengths 2 and 3 → the grant order is 01, 10, 01, 10, each with its own `done`, and one IDLE cycle between grants.
- **Abort:** requester 1 drops `req` during its RUN with `ctr_cnt` at 5 of a target of 20 → `ctr_en` drops and `gnt`=00 at the next edge, no `done` pulse, and a pending `req0` is granted next.
